// File: rtl/shift_arith_unit.sv
// Multi-cycle shift/concat/add unit with a bit-serial shift-add multiplier.
// Single start/done handshake; result fields hold until the next completion.
module shift_arith_unit #(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHW-1:0]     shamt,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               carry_out,
  output logic               err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    MULT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [2:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [SHW-1:0]     sh_r;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;

  logic [2*WIDTH-1:0] calc_res;
  logic               calc_c;
  logic               calc_e;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   lsl_v;
  logic [WIDTH-1:0]   a_sh1;
  logic signed [2*WIDTH-1:0] sext;
  logic [2*WIDTH-1:0] asr_v;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = (op == 3'd4) ? MULT : CALC;
      CALC: state_nx = DONE;
      MULT: if (cnt == LAST) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Sign-extend first so any shift amount saturates to copies of the MSB.
  always_comb begin
    sum      = {1'b0, a_r} + {1'b0, b_r};
    lsl_v    = a_r << sh_r;
    a_sh1    = {a_r[WIDTH-2:0], 1'b0};
    sext     = signed'({{WIDTH{a_r[WIDTH-1]}}, a_r});
    asr_v    = sext >>> sh_r;
    calc_res = '0;
    calc_c   = 1'b0;
    calc_e   = 1'b0;
    unique case (op_r)
      3'd0: calc_res = {{WIDTH{1'b0}}, lsl_v};
      3'd1: calc_res = asr_v;
      3'd2: calc_res = {a_r, a_sh1};
      3'd3: begin
        calc_res = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
        calc_c   = sum[WIDTH];
      end
      default: calc_e = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      sh_r      <= '0;
      cnt       <= '0;
      mcand     <= '0;
      acc       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          op_r  <= op;
          a_r   <= A;
          b_r   <= B;
          sh_r  <= shamt;
          cnt   <= '0;
          acc   <= '0;
          mcand <= {{WIDTH{1'b0}}, A};
        end
        CALC: begin
          result    <= calc_res;
          carry_out <= calc_c;
          err       <= calc_e;
        end
        MULT: if (cnt == LAST) begin
          result    <= acc;
          carry_out <= 1'b0;
          err       <= 1'b0;
        end else begin
          if (b_r[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          b_r   <= b_r >> 1;
          cnt   <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_arith_unit.sv
// Scoreboard bench for shift_arith_unit at WIDTH=4 and WIDTH=8.
// Expected responses queued at issue, compared by monitors on done.
module tb_shift_arith_unit;

  typedef struct {
    int res;
    int c;
    int e;
    int lat;
    int bsy;
    int e0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start4 = 1'b0;
  logic [2:0] op4 = '0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [1:0] sh4 = '0;
  logic       busy4, done4, cout4, err4;
  logic [7:0] res4;

  logic        start8 = 1'b0;
  logic [2:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [2:0]  sh8 = '0;
  logic        busy8, done8, cout8, err8;
  logic [15:0] res8;

  exp_t q4[$];
  exp_t q8[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int brun4 = 0;
  int brun8 = 0;

  shift_arith_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op(op4),
    .A(a4), .B(b4), .shamt(sh4), .busy(busy4), .done(done4),
    .result(res4), .carry_out(cout4), .err(err4)
  );

  shift_arith_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8),
    .A(a8), .B(b8), .shamt(sh8), .busy(busy8), .done(done8),
    .result(res8), .carry_out(cout8), .err(err8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int got, int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  task automatic score(string tag, exp_t ex, int r, int c, int e,
                       int b);
    chk({tag, "_result"}, r, ex.res);
    chk({tag, "_carry"}, c, ex.c);
    chk({tag, "_err"}, e, ex.e);
    chk({tag, "_latency"}, cyc - ex.e0 + 1, ex.lat);
    chk({tag, "_busy_cycles"}, b, ex.bsy);
  endtask

  always @(negedge clk) begin
    if (rst_n && done4) begin
      if (q4.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL w4_unexpected_done: got 1 expected 0");
      end else begin
        score("w4", q4.pop_front(), res4, cout4, err4, brun4);
      end
      brun4 = 0;
    end else if (busy4) brun4++;
    else brun4 = 0;
  end

  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL w8_unexpected_done: got 1 expected 0");
      end else begin
        score("w8", q8.pop_front(), res8, cout8, err8, brun8);
      end
      brun8 = 0;
    end else if (busy8) brun8++;
    else brun8 = 0;
  end

  // Operands are scrambled after the start cycle to prove latching.
  task automatic issue4(int op, int a, int b, int sh, int r, int c,
                        int e);
    exp_t ex;
    bit mul;
    mul = (op == 4);
    @(negedge clk);
    start4 = 1'b1;
    op4 = 3'(op);
    a4 = 4'(a);
    b4 = 4'(b);
    sh4 = 2'(sh);
    ex = '{res: r, c: c, e: e, lat: mul ? 6 : 2,
           bsy: mul ? 5 : 1, e0: cyc + 1};
    q4.push_back(ex);
    @(negedge clk);
    start4 = 1'b0;
    a4 = ~a4;
    b4 = ~b4;
    sh4 = ~sh4;
  endtask

  task automatic issue8(int op, int a, int b, int sh, int r, int c,
                        int e);
    exp_t ex;
    bit mul;
    mul = (op == 4);
    @(negedge clk);
    start8 = 1'b1;
    op8 = 3'(op);
    a8 = 8'(a);
    b8 = 8'(b);
    sh8 = 3'(sh);
    ex = '{res: r, c: c, e: e, lat: mul ? 10 : 2,
           bsy: mul ? 9 : 1, e0: cyc + 1};
    q8.push_back(ex);
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~a8;
    b8 = ~b8;
  endtask

  task automatic drain(bit w8);
    int t;
    t = 0;
    while ((w8 ? q8.size() : q4.size()) != 0 && t < 60) begin
      @(posedge clk);
      t++;
    end
    if (t >= 60) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no done expected done",
               w8 ? "w8" : "w4");
      if (w8) q8.delete();
      else q4.delete();
    end
  endtask

  initial begin
    #1;
    chk("reset_busy", busy4, 0);
    chk("reset_done", done4, 0);
    chk("reset_result", res4, 0);
    chk("reset_err", err4, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue4(3, 4'hF, 4'h1, 0, 8'h00, 1, 0); drain(0);
    issue4(1, 4'b1010, 0, 1, 8'hFD, 0, 0); drain(0);
    issue4(0, 4'b1011, 0, 1, 8'h06, 0, 0); drain(0);
    issue4(2, 4'b1011, 0, 1, 8'hB6, 0, 0); drain(0);
    issue4(4, 4'hF, 4'hF, 0, 8'hE1, 0, 0); drain(0);
    issue4(6, 4'h5, 4'h3, 0, 8'h00, 0, 1); drain(0);
    issue4(3, 4'h7, 4'h8, 0, 8'h0F, 0, 0); drain(0);
    issue4(0, 4'b0011, 0, 2, 8'h0C, 0, 0); drain(0);
    issue4(1, 4'b0110, 0, 3, 8'h00, 0, 0); drain(0);
    issue4(1, 4'b1000, 0, 3, 8'hFF, 0, 0); drain(0);
    issue4(4, 4'h3, 4'h5, 0, 8'h0F, 0, 0); drain(0);
    issue4(4, 4'h0, 4'h9, 0, 8'h00, 0, 0); drain(0);
    issue4(3, 4'h9, 4'h9, 0, 8'h02, 1, 0); drain(0);
    issue4(7, 4'h9, 4'h9, 0, 8'h00, 0, 1); drain(0);
    issue4(2, 4'b1000, 0, 0, 8'h80, 0, 0); drain(0);

    // A start pulse mid-multiply must neither disturb it nor queue.
    issue4(4, 4'hA, 4'hB, 0, 8'h6E, 0, 0);
    repeat (2) @(negedge clk);
    start4 = 1'b1;
    op4 = 3'd0;
    @(negedge clk);
    start4 = 1'b0;
    drain(0);

    issue8(4, 8'hFF, 8'hFF, 0, 16'hFE01, 0, 0);
    repeat (3) @(negedge clk);
    start8 = 1'b1;
    op8 = 3'd3;
    @(negedge clk);
    start8 = 1'b0;
    drain(1);
    issue8(3, 8'h12, 8'hF0, 0, 16'h0002, 1, 0); drain(1);
    issue8(1, 8'h80, 0, 7, 16'hFFFF, 0, 0); drain(1);
    repeat (4) @(negedge clk);

    issue4(3, 4'h9, 4'h9, 0, 8'h02, 1, 0); drain(0);
    @(negedge clk);
    start4 = 1'b1;
    op4 = 3'd4;
    a4 = 4'h5;
    b4 = 4'h5;
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy4, 0);
    chk("abort_done", done4, 0);
    chk("abort_result", res4, 0);
    chk("abort_carry", cout4, 0);
    chk("abort_err", err4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    issue4(3, 4'h1, 4'h2, 0, 8'h03, 0, 0); drain(0);
    repeat (3) @(negedge clk);
    chk("queue4_empty", q4.size(), 0);
    chk("queue8_empty", q8.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
